// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cpu_pkg                                                          |
// | Brief    : Shared stack defaults and the pointer-width helper              |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    localparam int STACK_DATA_W = 8;
    localparam int STACK_DEPTH  = 8;

    // The pointer needs one extra bit so it can represent a completely full stack.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stack_unit_if                                                    |
// | Brief    : Request and status bundle of the stack unit                     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface stack_unit_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH
);
    localparam int PTR_W = ptr_w(DEPTH);

    logic              push;
    logic              pop;
    logic              halt;
    logic              clr_err;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic [PTR_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, halt, clr_err, din,
        input  dout, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, halt, clr_err, din,
        output dout, count, empty, full, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stack_mem                                                        |
// | Brief    : DEPTH x DATA_W register array, sync write, async read, no reset |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module stack_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [AW-1:0]     waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [AW-1:0]     raddr,
    output logic      [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : stack_unit                                                       |
// | Brief    : LIFO stack with saturating pointer and sticky error flags       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module stack_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH
) (
    input  wire logic  clk,
    input  wire logic  rst,
    stack_unit_if.slave bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int AW    = $clog2(DEPTH);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic              ovf;
    logic              ovf_nxt;
    logic              unf;
    logic              unf_nxt;
    logic              is_empty;
    logic              is_full;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     top_addr;
    logic [DATA_W-1:0] rd_data;

    assign is_empty = (ptr == '0);
    assign is_full  = (ptr == PTR_W'(DEPTH));
    assign top_addr = AW'(ptr - PTR_W'(1));

    always_comb begin
        ptr_nxt = ptr;
        ovf_nxt = ovf;
        unf_nxt = unf;
        wr_en   = 1'b0;
        wr_addr = AW'(ptr);
        if (!bus.halt) begin
            // Clear first so an error raised in the same cycle takes priority.
            if (bus.clr_err) begin
                ovf_nxt = 1'b0;
                unf_nxt = 1'b0;
            end
            unique case ({bus.push, bus.pop})
                2'b10: begin
                    if (is_full) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        ptr_nxt = ptr + PTR_W'(1);
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        unf_nxt = 1'b1;
                    end else begin
                        ptr_nxt = ptr - PTR_W'(1);
                    end
                end
                2'b11: begin
                    if (!is_empty) begin
                        wr_en   = 1'b1;
                        wr_addr = top_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            ovf <= ovf_nxt;
            unf <= unf_nxt;
        end
    end

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (bus.din),
        .raddr (top_addr),
        .rdata (rd_data)
    );

    assign bus.dout      = is_empty ? '0 : rd_data;
    assign bus.count     = ptr;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = ovf;
    assign bus.underflow = unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_stack_unit                                                    |
// | Brief    : Directed bench for stack_unit with a queue-based reference model|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_stack_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   running;

    stack_unit_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the stack contents as a queue, top at the back.
    logic [DATA_W-1:0] mq[$];
    bit                m_ovf;
    bit                m_unf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!bus.halt) begin
            automatic int n  = mq.size();
            automatic bit eo = 1'b0;
            automatic bit eu = 1'b0;
            if (bus.push && !bus.pop) begin
                if (n == DEPTH) eo = 1'b1;
                else            mq.push_back(bus.din);
            end else if (bus.pop && !bus.push) begin
                if (n == 0) eu = 1'b1;
                else        void'(mq.pop_back());
            end else if (bus.push && bus.pop && n > 0) begin
                mq[n-1] = bus.din;
            end
            m_ovf = eo || (m_ovf && !bus.clr_err);
            m_unf = eu || (m_unf && !bus.clr_err);
        end
    end

    function automatic int exp_dout();
        return (mq.size() == 0) ? 0 : int'(mq[mq.size()-1]);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            chk("model_count",     int'(bus.count),     mq.size());
            chk("model_dout",      int'(bus.dout),      exp_dout());
            chk("model_empty",     int'(bus.empty),     int'(mq.size() == 0));
            chk("model_full",      int'(bus.full),      int'(mq.size() == DEPTH));
            chk("model_overflow",  int'(bus.overflow),  int'(m_ovf));
            chk("model_underflow", int'(bus.underflow), int'(m_unf));
        end
    end

    // One clocked operation; returns 2 time units after the edge with inputs idle.
    task automatic op(input bit ps, input bit pp, input logic [DATA_W-1:0] d,
                      input bit hl = 1'b0, input bit ce = 1'b0);
        bus.push    = ps;
        bus.pop     = pp;
        bus.din     = d;
        bus.halt    = hl;
        bus.clr_err = ce;
        @(posedge clk);
        #2;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.din     = '0;
        bus.halt    = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int c, input int d, input int ov, input int un);
        chk({tag, "_count"}, int'(bus.count),     c);
        chk({tag, "_dout"},  int'(bus.dout),      d);
        chk({tag, "_ovf"},   int'(bus.overflow),  ov);
        chk({tag, "_unf"},   int'(bus.underflow), un);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        running = 1'b0;
        rst = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.halt = 1'b0; bus.clr_err = 1'b0; bus.din = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        running = 1'b1;

        chk_state("reset", 0, 0, 0, 0);
        chk("reset_empty", int'(bus.empty), 1);
        chk("reset_full",  int'(bus.full),  0);

        // Basic push/pop ordering.
        op(1, 0, 8'h11); op(1, 0, 8'h22); op(1, 0, 8'h33);
        chk_state("push3", 3, 8'h33, 0, 0);
        op(0, 1, 8'h00);
        chk_state("pop1", 2, 8'h22, 0, 0);
        op(0, 1, 8'h00); op(0, 1, 8'h00);

        // Fill, then overflow attempt.
        for (int i = 0; i < DEPTH; i++) op(1, 0, 8'(8'h10 + i));
        chk("fill_full", int'(bus.full), 1);
        op(1, 0, 8'hAA);
        chk_state("ovf", 8, 8'h17, 1, 0);
        op(0, 0, 8'h00, 1'b0, 1'b1);
        chk_state("ovf_clr", 8, 8'h17, 0, 0);
        op(1, 1, 8'h5A);
        chk_state("swap_full", 8, 8'h5A, 0, 0);

        // Drain, then underflow and stickiness.
        for (int i = 0; i < DEPTH; i++) op(0, 1, 8'h00);
        op(0, 1, 8'h00);
        chk_state("unf", 0, 0, 0, 1);
        chk("unf_empty", int'(bus.empty), 1);
        op(1, 0, 8'h05);
        chk_state("unf_sticky", 1, 8'h05, 0, 1);
        op(0, 0, 8'h00, 1'b0, 1'b1);
        chk_state("unf_clr", 1, 8'h05, 0, 0);
        op(0, 1, 8'h00);
        op(0, 1, 8'h00, 1'b0, 1'b1);
        chk_state("err_wins_clr", 0, 0, 0, 1);
        op(0, 0, 8'h00, 1'b0, 1'b1);

        // Push+pop on empty does nothing.
        op(1, 1, 8'h66);
        chk_state("swap_empty", 0, 0, 0, 0);

        // Push+pop replaces top.
        op(1, 0, 8'h01); op(1, 0, 8'h02);
        op(1, 1, 8'h7F);
        chk_state("swap", 2, 8'h7F, 0, 0);

        // Halt freezes everything, including clr_err.
        op(0, 1, 8'h00); op(0, 1, 8'h00); op(0, 1, 8'h00);
        op(1, 0, 8'h01);
        chk_state("pre_halt", 1, 8'h01, 0, 1);
        for (int i = 0; i < 3; i++) op(1, 0, 8'h44, 1'b1, 1'b1);
        chk_state("halt", 1, 8'h01, 0, 1);
        op(0, 1, 8'h00, 1'b1, 1'b0);
        chk_state("halt_pop", 1, 8'h01, 0, 1);

        // Asynchronous reset mid-cycle.
        op(1, 0, 8'h02); op(1, 0, 8'h03); op(1, 0, 8'h04); op(1, 0, 8'h05);
        chk("pre_rst_count", int'(bus.count), 5);
        bus.push = 1'b1;
        bus.din  = 8'hEE;
        #1 rst = 1'b1;
        #1;
        chk_state("async_rst", 0, 0, 0, 0);
        chk("async_rst_empty", int'(bus.empty), 1);
        bus.push = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        op(1, 0, 8'h09);
        chk_state("post_rst", 1, 8'h09, 0, 0);

        op(0, 0, 8'h00);
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
